dac_ramp_seq: RTL and testbench

- Upstream sequencer for the two-channel DAC SPI writer.
- Replaces the fixed-word channel FSM/mux pair with a programmable staircase sweep. For each step it issues a DAC-A word, then a DAC-B word, then dwells a programmable time before advancing the code.
- Drives the writer through its strw/eow handshake and presents a stable 16-bit {control, code} word.

---
 rtl/dac_ramp_seq.sv | 151 +++++++++++++++
 tb/tb_dac_ramp_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_ramp_seq.sv
// dac_ramp_seq: staircase sweep sequencer feeding a two-channel DAC SPI writer.
// Each step writes a DAC-A word, then a DAC-B word, then dwells before
// advancing the code by a programmable step until the end bound is passed.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             one-cycle pulse; starts a sweep when idle
//   code_start_i        first code of the sweep
//   code_end_i          inclusive upper bound of the sweep
//   step_i              code increment per step (0 = single step)
//   dwell_i             extra idle cycles after each A/B pair
//   inv_b_i             B code is the complement of the A code when set
//   eow_i               end-of-write pulse from the SPI writer
//   strw_o              one-cycle start-write pulse to the SPI writer
//   din_o               {control nibble, code} word, stable until eow_i
//   selch_o             0 = channel A word, 1 = channel B word
//   busy_o              high from the cycle after start until eod_o
//   eod_o               one-cycle end-of-sweep pulse
//   code_o              current A code
module dac_ramp_seq #(
  parameter int unsigned DW    = 12,
  parameter int unsigned CW    = 29,
  parameter logic [3:0]  CTRLA = 4'b0011,
  parameter logic [3:0]  CTRLB = 4'b1011
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [DW-1:0] code_start_i,
  input  logic [DW-1:0] code_end_i,
  input  logic [DW-1:0] step_i,
  input  logic [CW-1:0] dwell_i,
  input  logic          inv_b_i,
  input  logic          eow_i,
  output logic          strw_o,
  output logic [DW+3:0] din_o,
  output logic          selch_o,
  output logic          busy_o,
  output logic          eod_o,
  output logic [DW-1:0] code_o
);

  typedef enum logic [2:0] {
    StIdle, StWrA, StWaitA, StWrB, StWaitB, StDwell, StNext, StDone
  } state_e;

  state_e        r_state;
  logic [DW-1:0] r_code;
  logic [DW-1:0] r_end;
  logic [DW-1:0] r_step;
  logic [CW-1:0] r_dwell;
  logic          r_inv;
  logic [CW-1:0] r_cnt;
  logic          r_strw;
  logic [DW+3:0] r_din;
  logic          r_selch;
  logic          r_busy;
  logic          r_eod;

  logic [DW:0]   w_sum;
  logic [DW-1:0] w_code_b;
  logic          w_stop;

  // One extra bit so a sum past all-ones is detected instead of wrapping.
  assign w_sum    = {1'b0, r_code} + {1'b0, r_step};
  // All-ones minus code is the bitwise complement.
  assign w_code_b = r_inv ? ~r_code : r_code;
  assign w_stop   = (r_step == '0) || w_sum[DW] || (w_sum > {1'b0, r_end});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_code  <= '0;
      r_end   <= '0;
      r_step  <= '0;
      r_dwell <= '0;
      r_inv   <= 1'b0;
      r_cnt   <= '0;
      r_strw  <= 1'b0;
      r_din   <= '0;
      r_selch <= 1'b0;
      r_busy  <= 1'b0;
      r_eod   <= 1'b0;
    end else begin
      // Pulse outputs default low; only the transitions below raise them.
      r_strw <= 1'b0;
      r_eod  <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start_i) begin
            r_end   <= code_end_i;
            r_step  <= step_i;
            r_dwell <= dwell_i;
            r_inv   <= inv_b_i;
            r_code  <= code_start_i;
            r_busy  <= 1'b1;
            r_strw  <= 1'b1;
            r_selch <= 1'b0;
            r_din   <= {CTRLA, code_start_i};
            r_state <= StWrA;
          end
        end
        StWrA:   r_state <= StWaitA;
        StWaitA: begin
          if (eow_i) begin
            r_strw  <= 1'b1;
            r_selch <= 1'b1;
            r_din   <= {CTRLB, w_code_b};
            r_state <= StWrB;
          end
        end
        StWrB:   r_state <= StWaitB;
        StWaitB: begin
          if (eow_i) begin
            r_cnt   <= r_dwell;
            r_state <= StDwell;
          end
        end
        StDwell: begin
          if (r_cnt == '0) r_state <= StNext;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        StNext: begin
          if (w_stop) begin
            r_eod   <= 1'b1;
            r_state <= StDone;
          end else begin
            r_code  <= w_sum[DW-1:0];
            r_strw  <= 1'b1;
            r_selch <= 1'b0;
            r_din   <= {CTRLA, w_sum[DW-1:0]};
            r_state <= StWrA;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign strw_o  = r_strw;
  assign din_o   = r_din;
  assign selch_o = r_selch;
  assign busy_o  = r_busy;
  assign eod_o   = r_eod;
  assign code_o  = r_code;

endmodule

// File: tb/tb_dac_ramp_seq.sv
// Bench for dac_ramp_seq: a writer model answers strw_o with eow_i, a
// reference model queues expected words and end-of-sweep markers, and a
// monitor pops and compares whenever the DUT emits strw_o or eod_o.
module tb_dac_ramp_seq;

  logic        clk = 1'b0;
  logic        rst_i, start_i, inv_b_i, eow_i;
  logic [11:0] code_start_i, code_end_i, step_i;
  logic [28:0] dwell_i;
  logic        strw_o, selch_o, busy_o, eod_o;
  logic [15:0] din_o;
  logic [11:0] code_o;

  int tests = 0;
  int fails = 0;

  // Scoreboard entry: bit 17 marks end-of-sweep, else {selch, din}.
  logic [17:0] sb[$];
  localparam logic [17:0] EodTag = 18'h20000;

  int lat_cfg   = 4;
  bit spur_en   = 1'b0;
  int cur_dwell = 0;
  int last_code = 0;

  always #5 clk = ~clk;

  dac_ramp_seq dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .code_start_i (code_start_i),
    .code_end_i   (code_end_i),
    .step_i       (step_i),
    .dwell_i      (dwell_i),
    .inv_b_i      (inv_b_i),
    .eow_i        (eow_i),
    .strw_o       (strw_o),
    .din_o        (din_o),
    .selch_o      (selch_o),
    .busy_o       (busy_o),
    .eod_o        (eod_o),
    .code_o       (code_o)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: list every word of the sweep in order, then the end marker.
  function automatic int model(input int s, input int e, input int st, input bit inv);
    int c = s;
    forever begin
      sb.push_back(18'(32'h3000 + c));
      sb.push_back(18'(32'h1B000 + (inv ? 4095 - c : c)));
      if (st == 0 || c + st > 4095 || c + st > e) break;
      c = c + st;
    end
    sb.push_back(EodTag);
    return c;
  endfunction

  // Writer model: eow_i lat_cfg cycles after each strw_o. With spur_en it
  // also pulses eow_i in the strw_o cycle, shortly after a B-word eow_i,
  // and continuously while idle; all of these must be ignored.
  initial begin
    int wcnt = -1;
    int dcnt = -1;
    bit wsel = 1'b0;
    eow_i = 1'b0;
    forever begin
      @(negedge clk);
      eow_i = 1'b0;
      if (wcnt == 0) begin
        eow_i = 1'b1;
        wcnt  = -1;
        if (wsel && spur_en) dcnt = 1;
      end else if (wcnt > 0) begin
        wcnt--;
      end else if (dcnt == 0) begin
        eow_i = 1'b1;
        dcnt  = -1;
      end else if (dcnt > 0) begin
        dcnt--;
      end
      if (strw_o) begin
        wcnt = lat_cfg - 1;
        wsel = selch_o;
        if (spur_en) eow_i = 1'b1;
      end
      if (spur_en && !busy_o) eow_i = 1'b1;
    end
  end

  // Monitor
  initial begin
    int          cyc = 0;
    int          eowb_cyc = 0;
    bit          have_eowb = 1'b0;
    bit          outstanding = 1'b0;
    bit          just_strw = 1'b0;
    bit          stable = 1'b1;
    bit          last_sel = 1'b0;
    logic [15:0] held = '0;
    logic [17:0] exp;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_i) begin
        outstanding = 1'b0;
        just_strw   = 1'b0;
        have_eowb   = 1'b0;
        sb.delete();
      end else begin
        // An eow_i at the edge that ends the strw_o cycle is spurious.
        if (eow_i && outstanding && !just_strw) begin
          chk("din_stable_in_wait", stable, 1);
          outstanding = 1'b0;
          have_eowb   = last_sel;
          eowb_cyc    = cyc;
        end
        just_strw = 1'b0;
        if (outstanding && !strw_o && din_o != held) stable = 1'b0;
        if (strw_o) begin
          chk("strw_without_eow", outstanding, 0);
          if (sb.size() == 0) begin
            chk("unexpected_strw_word", {selch_o, din_o}, 18'h3FFFF);
          end else begin
            exp = sb.pop_front();
            chk("sb_word", {1'b0, selch_o, din_o}, exp);
          end
          if (!selch_o && have_eowb) chk("dwell_gap", cyc - eowb_cyc, cur_dwell + 2);
          have_eowb   = 1'b0;
          outstanding = 1'b1;
          held        = din_o;
          stable      = 1'b1;
          just_strw   = 1'b1;
          last_sel    = selch_o;
        end
        if (eod_o) begin
          have_eowb = 1'b0;
          if (sb.size() == 0) begin
            chk("unexpected_eod", 1, 0);
          end else begin
            exp = sb.pop_front();
            chk("sb_eod", exp, EodTag);
          end
        end
      end
    end
  end

  task automatic scramble();
    code_start_i = 12'($urandom);
    code_end_i   = 12'($urandom);
    step_i       = 12'($urandom);
    dwell_i      = 29'($urandom);
    inv_b_i      = 1'($urandom);
  endtask

  task automatic begin_sweep(input int s, input int e, input int st, input int dw,
                             input bit inv, input int lat, input bit spur);
    @(negedge clk);
    lat_cfg      = lat;
    spur_en      = spur;
    cur_dwell    = dw;
    code_start_i = 12'(s);
    code_end_i   = 12'(e);
    step_i       = 12'(st);
    dwell_i      = 29'(dw);
    inv_b_i      = inv;
    last_code    = model(s, e, st, inv);
    start_i      = 1'b1;
    @(posedge clk);
    #1;
    chk("start_latency_strw", strw_o, 1);
    chk("busy_rise", busy_o, 1);
    @(negedge clk);
    start_i = 1'b0;
    scramble();
  endtask

  task automatic wait_end(input bit poke);
    int n       = 0;
    bit seen    = 1'b0;
    bit busy_ok = 1'b1;
    while (!seen && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
      if (!busy_o) busy_ok = 1'b0;
      if (eod_o) seen = 1'b1;
      start_i = poke && (n == 3 || n == 15);
    end
    start_i = 1'b0;
    chk("eod_seen", seen, 1);
    chk("busy_through_sweep", busy_ok, 1);
    @(posedge clk);
    #1;
    chk("busy_fall", busy_o, 0);
    chk("eod_one_cycle", eod_o, 0);
    chk("code_hold", code_o, last_code);
    chk("sb_empty", sb.size(), 0);
    sb.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_strw", strw_o, 0);
    chk("rst_eod", eod_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_selch", selch_o, 0);
    chk("rst_din", din_o, 0);
    chk("rst_code", code_o, 0);
  endtask

  initial begin
    bit found;
    bit quiet;
    rst_i   = 1'b1;
    start_i = 1'b0;
    scramble();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_i = 1'b0;

    // Basic sweep, slow writer
    begin_sweep(12'h000, 12'h004, 2, 3, 1'b0, 40, 1'b0);
    wait_end(1'b0);
    // Inverted B, single code
    begin_sweep(12'h100, 12'h100, 1, 2, 1'b1, 7, 1'b0);
    wait_end(1'b0);
    // Overflow guard, with spurious eow_i
    begin_sweep(12'hFF0, 12'hFFF, 12'h10, 1, 1'b0, 5, 1'b1);
    wait_end(1'b0);
    // Degenerate: step 0, start above end, start pulses mid-sweep
    begin_sweep(12'h800, 12'h100, 0, 0, 1'b0, 10, 1'b1);
    wait_end(1'b1);

    // Reset while waiting for the B-word eow_i
    begin_sweep(12'h200, 12'h300, 12'h10, 2, 1'b0, 20, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(posedge clk);
      #1;
      if (strw_o && selch_o) found = 1'b1;
    end
    chk("reach_wait_b", found, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_i = 1'b0;
    quiet = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (strw_o || busy_o || eod_o) quiet = 1'b0;
    end
    chk("quiet_after_reset", quiet, 1);
    sb.delete();
    begin_sweep(12'h200, 12'h230, 12'h10, 1, 1'b0, 6, 1'b0);
    wait_end(1'b0);

    // Randomized sweeps
    for (int i = 0; i < 8; i++) begin
      int s, e, st, dw, lat;
      bit inv, spur;
      s = $urandom_range(0, 4095);
      e = s + $urandom_range(0, 120);
      if (e > 4095) e = 4095;
      if ($urandom_range(0, 5) == 0) e = $urandom_range(0, s);
      st   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 60);
      dw   = $urandom_range(0, 6);
      lat  = $urandom_range(1, 8);
      inv  = 1'($urandom);
      spur = 1'($urandom);
      begin_sweep(s, e, st, dw, inv, lat, spur);
      wait_end(1'($urandom));
    end

    spur_en = 1'b0;
    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
